// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master RAM arbiter: FSM states and owner encodings.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; req[0]=CPU, req[1]=DMA.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       grant,
  output logic       winner
);

  always_comb begin
    grant = |req;
    // A tie goes to whoever did not win last; a lone request wins outright.
    if (req == 2'b11) winner = ~last_owner;
    else              winner = req[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port RAM between the CPU and DMA masters, one access at a time,
// with round-robin tie breaking and fully registered outputs.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic          dma_be,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_re,
  output logic          ram_be,
  input  logic [DW-1:0] ram_rdata,
  output logic          owner
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);

  state_t          state_reg, state_next;
  logic            last_owner_reg, last_owner_next;
  logic            owner_reg, owner_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [AW-1:0]   ram_addr_reg, ram_addr_next;
  logic [DW-1:0]   ram_wdata_reg, ram_wdata_next;
  logic            ram_be_reg, ram_be_next;
  logic            ram_we_reg, ram_we_next;
  logic            ram_re_reg, ram_re_next;
  logic [DW-1:0]   cpu_rdata_reg, cpu_rdata_next;
  logic [DW-1:0]   dma_rdata_reg, dma_rdata_next;
  logic            cpu_ack_reg, cpu_ack_next;
  logic            dma_ack_reg, dma_ack_next;

  logic grant;
  logic winner;

  rr_arb2 u_rr_arb2 (
    .req        ({dma_req, cpu_req}),
    .last_owner (last_owner_reg),
    .grant      (grant),
    .winner     (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_owner_reg <= OWN_DMA;
      owner_reg      <= OWN_CPU;
      cnt_reg        <= '0;
      ram_addr_reg   <= '0;
      ram_wdata_reg  <= '0;
      ram_be_reg     <= 1'b0;
      ram_we_reg     <= 1'b0;
      ram_re_reg     <= 1'b0;
      cpu_rdata_reg  <= '0;
      dma_rdata_reg  <= '0;
      cpu_ack_reg    <= 1'b0;
      dma_ack_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
      owner_reg      <= owner_next;
      cnt_reg        <= cnt_next;
      ram_addr_reg   <= ram_addr_next;
      ram_wdata_reg  <= ram_wdata_next;
      ram_be_reg     <= ram_be_next;
      ram_we_reg     <= ram_we_next;
      ram_re_reg     <= ram_re_next;
      cpu_rdata_reg  <= cpu_rdata_next;
      dma_rdata_reg  <= dma_rdata_next;
      cpu_ack_reg    <= cpu_ack_next;
      dma_ack_reg    <= dma_ack_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    owner_next      = owner_reg;
    cnt_next        = cnt_reg;
    ram_addr_next   = ram_addr_reg;
    ram_wdata_next  = ram_wdata_reg;
    ram_be_next     = ram_be_reg;
    ram_we_next     = 1'b0;
    ram_re_next     = 1'b0;
    cpu_rdata_next  = cpu_rdata_reg;
    dma_rdata_next  = dma_rdata_reg;
    cpu_ack_next    = 1'b0;
    dma_ack_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        // The RAM address/data/be registers double as the latched request copy.
        if (grant) begin
          state_next      = ACC;
          owner_next      = winner;
          last_owner_next = winner;
          if (winner == OWN_DMA) begin
            ram_addr_next  = dma_addr;
            ram_wdata_next = dma_wdata;
            ram_be_next    = dma_be;
            ram_we_next    = dma_we;
            ram_re_next    = ~dma_we;
          end else begin
            ram_addr_next  = cpu_addr;
            ram_wdata_next = cpu_wdata;
            ram_be_next    = cpu_be;
            ram_we_next    = cpu_we;
            ram_re_next    = ~cpu_we;
          end
        end
      end
      ACC: begin
        if (ram_we_reg) begin
          state_next   = DONE;
          cpu_ack_next = (owner_reg == OWN_CPU);
          dma_ack_next = (owner_reg == OWN_DMA);
        end else begin
          state_next = WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
          if (owner_reg == OWN_DMA) begin
            dma_rdata_next = ram_rdata;
            dma_ack_next   = 1'b1;
          end else begin
            cpu_rdata_next = ram_rdata;
            cpu_ack_next   = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cpu_rdata = cpu_rdata_reg;
  assign cpu_ack   = cpu_ack_reg;
  assign dma_rdata = dma_rdata_reg;
  assign dma_ack   = dma_ack_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign ram_we    = ram_we_reg;
  assign ram_re    = ram_re_reg;
  assign ram_be    = ram_be_reg;
  assign owner     = owner_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at RD_LAT=1 with a RAM model,
// one at RD_LAT=3 with a pipelined read-pattern source.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance A (RD_LAT=1)
  logic        cpu_req, cpu_we, cpu_be, cpu_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_be, dma_ack;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we, ram_re, ram_be, owner;
  logic [15:0] mem [0:65535];

  // instance B (RD_LAT=3)
  logic        b_cpu_req, b_cpu_ack, b_dma_ack, b_ram_we, b_ram_re, b_ram_be, b_owner;
  logic [15:0] b_cpu_addr, b_cpu_rdata, b_dma_rdata, b_ram_addr, b_ram_wdata;
  logic [15:0] b_s1, b_s2, b_s3;

  mem_arbiter #(.AW(16), .DW(16), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_be(ram_be), .ram_rdata(ram_rdata), .owner(owner)
  );

  mem_arbiter #(.AW(16), .DW(16), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(1'b0), .cpu_be(1'b0), .cpu_addr(b_cpu_addr),
    .cpu_wdata(16'h0000), .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
    .dma_req(1'b0), .dma_we(1'b0), .dma_be(1'b0), .dma_addr(16'h0000),
    .dma_wdata(16'h0000), .dma_rdata(b_dma_rdata), .dma_ack(b_dma_ack),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_we(b_ram_we), .ram_re(b_ram_re),
    .ram_be(b_ram_be), .ram_rdata(b_s3), .owner(b_owner)
  );

  // RAM A: one-cycle registered read; reset preloads the test word
  always @(posedge clk) begin
    if (reset) mem[16'h0040] <= 16'h1234;
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  // RAM B: data = addr ^ 0xA5A5, valid three cycles after the re cycle, else 0
  always @(posedge clk) begin
    b_s1 <= b_ram_re ? (b_ram_addr ^ 16'hA5A5) : 16'h0000;
    b_s2 <= b_s1;
    b_s3 <= b_s2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic port, output int lat);
    lat = 0;
    do begin
      tick;
      lat++;
    end while (!(port ? dma_ack : cpu_ack) && lat < 20);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("we_re_excl_a", 32'(ram_we & ram_re), 32'd0);
      check("we_re_excl_b", 32'(b_ram_we & b_ram_re), 32'd0);
    end
  end

  int lat;

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_be = 0; dma_addr = 0; dma_wdata = 0;
    b_cpu_req = 0; b_cpu_addr = 0;
    repeat (3) tick;
    check("rst_owner", owner, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_dma_ack", dma_ack, 0);
    check("rst_ram_re", ram_re, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    reset = 1'b0;
    tick;

    // 1: CPU read of 0x0040
    cpu_we = 0; cpu_addr = 16'h0040; cpu_req = 1;
    tick;
    check("t1_re", ram_re, 1);
    check("t1_we", ram_we, 0);
    check("t1_addr", ram_addr, 16'h0040);
    check("t1_owner", owner, 0);
    cpu_addr = 16'hFFFF;
    tick;
    check("t1_re_one_cycle", ram_re, 0);
    check("t1_early_ack", cpu_ack, 0);
    tick;
    check("t1_ack", cpu_ack, 1);
    check("t1_rdata", cpu_rdata, 16'h1234);
    check("t1_dma_ack", dma_ack, 0);
    cpu_req = 0;
    tick;
    check("t1_ack_pulse", cpu_ack, 0);
    check("t1_rdata_hold", cpu_rdata, 16'h1234);

    // 2: DMA write 0x0100 <= 0xBEEF, then CPU reads it back
    dma_we = 1; dma_be = 1; dma_addr = 16'h0100; dma_wdata = 16'hBEEF; dma_req = 1;
    tick;
    check("t2_we", ram_we, 1);
    check("t2_re", ram_re, 0);
    check("t2_be", ram_be, 1);
    check("t2_wdata", ram_wdata, 16'hBEEF);
    check("t2_addr", ram_addr, 16'h0100);
    check("t2_owner", owner, 1);
    dma_wdata = 16'h0000;
    tick;
    check("t2_we_one_cycle", ram_we, 0);
    check("t2_dma_ack", dma_ack, 1);
    check("t2_cpu_ack", cpu_ack, 0);
    dma_req = 0; dma_we = 0; dma_be = 0;
    tick;
    cpu_addr = 16'h0100; cpu_req = 1;
    wait_ack(1'b0, lat);
    check("t2_rd_lat", lat, 3);
    check("t2_rd_data", cpu_rdata, 16'hBEEF);
    check("t2_dma_rdata_kept", dma_rdata, 16'h0000);
    cpu_req = 0;
    tick;

    // 3: both held after reset -> CPU, DMA, CPU, DMA
    reset = 1'b1;
    tick;
    reset = 1'b0;
    cpu_addr = 16'h0040; dma_addr = 16'h0040; dma_we = 0;
    cpu_req = 1; dma_req = 1;
    for (int g = 0; g < 4; g++) begin
      int n;
      n = 0;
      while (!cpu_ack && !dma_ack && n < 20) begin
        tick;
        n++;
      end
      check("t3_grant", dma_ack, 32'(g % 2));
      check("t3_owner", owner, 32'(g % 2));
      check("t3_one_ack", 32'(cpu_ack ^ dma_ack), 1);
      if (dma_ack) dma_req = 0;
      else         cpu_req = 0;
      tick;
      cpu_req = 1; dma_req = 1;
    end
    cpu_req = 0; dma_req = 0;

    // 4: DMA arrives during a CPU ACC and wins the next IDLE
    cpu_addr = 16'h0040; cpu_req = 1;
    tick;
    check("t4_cpu_first", owner, 0);
    dma_we = 1; dma_be = 0; dma_addr = 16'h0200; dma_wdata = 16'h5555; dma_req = 1;
    tick;
    tick;
    check("t4_cpu_ack", cpu_ack, 1);
    check("t4_no_dma_ack", dma_ack, 0);
    cpu_req = 0;
    tick;
    check("t4_done_ignores_req", ram_we, 0);
    cpu_req = 1;
    tick;
    check("t4_dma_owner", owner, 1);
    check("t4_dma_we", ram_we, 1);
    check("t4_dma_wdata", ram_wdata, 16'h5555);
    check("t4_dma_addr", ram_addr, 16'h0200);
    tick;
    check("t4_dma_ack", dma_ack, 1);
    check("t4_cpu_waits", cpu_ack, 0);
    dma_req = 0; dma_we = 0;
    tick;
    tick;
    check("t4_cpu_owner", owner, 0);
    check("t4_cpu_re", ram_re, 1);
    wait_ack(1'b0, lat);
    check("t4_cpu_lat", lat, 2);
    check("t4_cpu_rdata", cpu_rdata, 16'h1234);
    cpu_req = 0;
    tick;

    // 5: reset during WAIT aborts the read; next tie goes to CPU
    cpu_addr = 16'h0100; cpu_req = 1;
    tick;
    tick;
    reset = 1'b1;
    tick;
    check("t5_re", ram_re, 0);
    check("t5_we", ram_we, 0);
    check("t5_no_ack", cpu_ack, 0);
    check("t5_owner", owner, 0);
    check("t5_rdata_clr", cpu_rdata, 0);
    cpu_req = 0; reset = 1'b0;
    tick;
    check("t5_still_no_ack", cpu_ack, 0);
    cpu_addr = 16'h0040; dma_addr = 16'h0040; dma_we = 0;
    cpu_req = 1; dma_req = 1;
    tick;
    check("t5_tie_owner", owner, 0);
    check("t5_tie_re", ram_re, 1);
    dma_req = 0;
    wait_ack(1'b0, lat);
    check("t5_lat", lat, 2);
    check("t5_rdata", cpu_rdata, 16'h1234);
    cpu_req = 0;
    tick;

    // 6: RD_LAT=3 instance
    b_cpu_addr = 16'h0033; b_cpu_req = 1;
    tick;
    check("t6_re", b_ram_re, 1);
    check("t6_addr", b_ram_addr, 16'h0033);
    tick;
    check("t6_re_one_cycle", b_ram_re, 0);
    tick;
    tick;
    check("t6_early_ack", b_cpu_ack, 0);
    tick;
    check("t6_ack", b_cpu_ack, 1);
    check("t6_rdata", b_cpu_rdata, 16'hA596);
    b_cpu_req = 0;
    tick;
    b_cpu_addr = 16'h0007; b_cpu_req = 1;
    lat = 0;
    do begin
      tick;
      lat++;
    end while (!b_cpu_ack && lat < 20);
    check("t6b_lat", lat, 5);
    check("t6b_rdata", b_cpu_rdata, 16'hA5A2);
    b_cpu_req = 0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port system RAM between the CPU memory port and a second bus master, such as the UART/DMA engine.
- Each requester uses a req/ack handshake. The block runs one RAM access at a time and sequences RAM control (addr, wdata, we, re, be).
- It returns read data to the winning port. A round-robin policy prevents either master from starving the other.

Parameters:
AW, 16, address width
DW, 16, data width
RD_LAT, 1, RAM read latency in cycles (>=1) from the re cycle to valid ram_rdata

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_be  in  1  byte-enable passthrough
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  CPU read data, valid while cpu_ack is high
cpu_ack  out  1  one-cycle completion pulse
dma_req  in  1  DMA request, held until dma_ack
dma_we  in  1  1=write
dma_be  in  1  byte-enable
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_rdata  out  DW  DMA read data, valid while dma_ack is high
dma_ack  out  1  one-cycle completion pulse
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_we  out  1  RAM write strobe
ram_re  out  1  RAM read strobe
ram_be  out  1  RAM byte-enable
ram_rdata  in  DW  RAM read data
owner  out  1  current/last grant: 0=CPU, 1=DMA

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. All outputs are 0 and the state is IDLE. last_owner resets to DMA, so the first tie goes to the CPU.
- All outputs are registered.
- States: IDLE, ACC, WAIT, DONE.
- IDLE: samples cpu_req/dma_req.
  - If only one is high, that port wins.
  - If both are high, the winner is ~last_owner.
  - If neither is high, stay in IDLE.
  - On a grant: latch the winner's we/be/addr/wdata, set owner and last_owner, go to ACC.
- ACC (exactly one cycle): drive ram_addr/ram_wdata/ram_be from the latched request. Assert ram_we (write) or ram_re (read) for this cycle only.
  - Write: go to DONE.
  - Read: load the latency counter with RD_LAT-1, go to WAIT.
- WAIT: decrement the counter. When it reaches 0, capture ram_rdata into the winning port's rdata register and go to DONE.
  - With RD_LAT=1, WAIT lasts one cycle and samples ram_rdata at its end.
- DONE: assert the winner's ack for one cycle; rdata holds its value. Requests are ignored in DONE. Return to IDLE.
- The requester must drop req on the edge where it sees ack. A req still high in IDLE is a new request.
- Latency, with req first sampled at edge k while IDLE:
  - write: ack high in cycle k+2;
  - read: ack high in cycle k+2+RD_LAT.
- Throughput: one write per 3 cycles; one read per 3+RD_LAT cycles.
- The losing port sees no ack; it is served at the next IDLE, because last_owner has flipped.
- Port request fields may change once the grant is taken; the arbiter uses its latched copy.
- ram_we and ram_re are never high together, and never high outside ACC.
- Reset in any state aborts the in-flight access: no ack, outputs cleared on the next edge, last_owner back to DMA.
- Non-winner rdata registers keep their prior value.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ACC, WAIT, DONE);
  - owner encodings OWN_CPU=0, OWN_DMA=1.
- One sub-module: rr_arb2 (combinational 2-way round-robin pick from req[1:0] and last_owner).

Test Plan:
1. RAM[0x0040]=0x1234; cpu_req read 0x0040 at edge k -> ram_re high only in cycle k+1 with ram_addr=0x0040; cpu_ack in k+3 with cpu_rdata=0x1234; dma_ack stays 0.
2. DMA write addr 0x0100, data 0xBEEF, be=1 -> ram_we high one cycle with ram_be=1, ram_wdata=0xBEEF; dma_ack at k+2. A following CPU read of 0x0100 returns 0xBEEF.
3. After reset, cpu_req and dma_req both held high, each re-asserted after its ack -> grant order CPU, DMA, CPU, DMA; owner toggles 0,1,0,1.
4. CPU issues back-to-back reads; dma_req rises during a CPU ACC -> DMA is granted at the very next IDLE, and the CPU waits one full access.
5. reset asserted during WAIT of a CPU read -> no cpu_ack, all RAM strobes 0 next cycle. A subsequent tie is granted to the CPU.
6. RD_LAT=3 build, CPU read at edge k -> ram_re in k+1, cpu_ack in k+5 with correct data.
